// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the multi-cycle divide sequencer.
package div_sequencer_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DIV_CYCLES_DEF = 32;
    localparam int STATE_W        = 3;

    localparam logic [DATA_WIDTH_DEF-1:0] DIV_ZERO_QUOTIENT = '1;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// Request/result bundle between the EXE-stage controller and the divide sequencer.
interface div_sequencer_if #(parameter int DATA_WIDTH = 32);

    logic                  i_req;
    logic                  i_signed;
    logic [DATA_WIDTH-1:0] i_dividend;
    logic [DATA_WIDTH-1:0] i_divisor;
    logic                  i_flush;
    logic                  o_div_busy;
    logic                  o_div_done;
    logic [DATA_WIDTH-1:0] o_quotient;
    logic [DATA_WIDTH-1:0] o_remainder;

    modport master (
        output i_req, i_signed, i_dividend, i_divisor, i_flush,
        input  o_div_busy, o_div_done, o_quotient, o_remainder
    );

    modport slave (
        input  i_req, i_signed, i_dividend, i_divisor, i_flush,
        output o_div_busy, o_div_done, o_quotient, o_remainder
    );

endinterface

// File: rtl/div_core.sv
// Restoring radix-2 divider datapath: one quotient bit per i_step on unsigned magnitudes.
module div_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [DATA_WIDTH-1:0] i_dividend_mag,
    input  logic [DATA_WIDTH-1:0] i_divisor_mag,
    output logic [DATA_WIDTH-1:0] o_quotient_mag,
    output logic [DATA_WIDTH-1:0] o_remainder_mag
);

    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_div;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;

    // Partial remainder is one bit wider than the divisor so the trial subtract never wraps.
    assign w_shift = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend_mag;
            r_div <= i_divisor_mag;
        end else if (i_step) begin
            if (!w_diff[DATA_WIDTH]) begin
                r_rem <= w_diff[DATA_WIDTH-1:0];
                r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[DATA_WIDTH-1:0];
                r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_quotient_mag  = r_quo;
    assign o_remainder_mag = r_rem;

endmodule

// File: rtl/div_sequencer.sv
// EXE-stage divide controller: accepts one request, runs the core for DIV_CYCLES steps,
// applies sign fix-up, and reports busy/done; a flush abandons the op without touching results.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic           clk,
    input  logic           reset,
    div_sequencer_if.slave bus
);

    state_t                r_state, w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_signed, r_q_neg, r_r_neg;
    logic [DATA_WIDTH-1:0] r_dividend, r_divisor;
    logic [DATA_WIDTH-1:0] r_quotient, r_remainder;
    logic [DATA_WIDTH-1:0] w_dividend_mag, w_divisor_mag;
    logic [DATA_WIDTH-1:0] w_q_mag, w_r_mag, w_q_fix, w_r_fix;
    logic                  w_accept, w_div_zero, w_last, w_dvd_neg, w_dvs_neg;

    assign w_accept   = (r_state == IDLE) && bus.i_req && !bus.i_flush;
    assign w_div_zero = (r_divisor == '0);
    assign w_last     = (r_cnt == CNT_W'(DIV_CYCLES - 1));
    assign w_dvd_neg  = r_signed && r_dividend[DATA_WIDTH-1];
    assign w_dvs_neg  = r_signed && r_divisor[DATA_WIDTH-1];

    // 0x80000000 negates to itself and is then read as an unsigned magnitude.
    assign w_dividend_mag = w_dvd_neg ? -r_dividend : r_dividend;
    assign w_divisor_mag  = w_dvs_neg ? -r_divisor  : r_divisor;
    assign w_q_fix        = r_q_neg ? -w_q_mag : w_q_mag;
    assign w_r_fix        = r_r_neg ? -w_r_mag : w_r_mag;

    div_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .clk             (clk),
        .reset           (reset),
        .i_load          (r_state == PREP),
        .i_step          (r_state == ITER),
        .i_dividend_mag  (w_dividend_mag),
        .i_divisor_mag   (w_divisor_mag),
        .o_quotient_mag  (w_q_mag),
        .o_remainder_mag (w_r_mag)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = PREP;
            PREP:    w_next = w_div_zero ? DONE : ITER;
            ITER:    if (w_last) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (bus.i_flush && r_state != IDLE) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_signed    <= 1'b0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            if (w_accept) begin
                r_signed   <= bus.i_signed;
                r_dividend <= bus.i_dividend;
                r_divisor  <= bus.i_divisor;
            end
            case (r_state)
                PREP: begin
                    r_cnt   <= '0;
                    r_q_neg <= w_dvd_neg ^ w_dvs_neg;
                    r_r_neg <= w_dvd_neg;
                    if (w_div_zero && !bus.i_flush) begin
                        r_quotient  <= DATA_WIDTH'(DIV_ZERO_QUOTIENT);
                        r_remainder <= r_dividend;
                    end
                end
                ITER: r_cnt <= r_cnt + CNT_W'(1);
                FIX: begin
                    if (!bus.i_flush) begin
                        r_quotient  <= w_q_fix;
                        r_remainder <= w_r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_div_busy  = (r_state != IDLE);
    assign bus.o_div_done  = (r_state == DONE);
    assign bus.o_quotient  = r_quotient;
    assign bus.o_remainder = r_remainder;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench: directed cases plus random traffic against a cycle-count/arithmetic model.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 32 + 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    div_sequencer_if #(.DATA_WIDTH(W)) bus();

    div_sequencer #(.DATA_WIDTH(W), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural result: truncating division, remainder takes the dividend's sign.
    function automatic void ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Model: cycles left in the busy window; 1 means the done cycle.
    int          m_cnt = 0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_q = '0; m_r = '0;
        end else if (m_cnt == 1) begin
            m_cnt = 0;
        end else if (m_cnt > 1) begin
            if (bus.i_flush) m_cnt = 0;
            else begin
                m_cnt--;
                if (m_cnt == 1) begin m_q = p_q; m_r = p_r; end
            end
        end else if (bus.i_req && !bus.i_flush) begin
            ref_div(bus.i_signed, bus.i_dividend, bus.i_divisor, p_q, p_r);
            m_cnt = (bus.i_divisor == '0) ? 2 : LAT;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", W'(bus.o_div_busy), W'(m_cnt > 0));
            chk("done", W'(bus.o_div_done), W'(m_cnt == 1));
            chk("quotient", bus.o_quotient, m_q);
            chk("remainder", bus.o_remainder, m_r);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.i_req = 1'b1; bus.i_signed = s; bus.i_dividend = a; bus.i_divisor = b;
    endtask

    task automatic run_op(input string nm, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input int elat);
        int n;
        drive_req(s, a, b);
        tick();
        bus.i_req = 1'b0;
        n = 1;
        while (!bus.o_div_done && n < 60) begin
            tick();
            n++;
        end
        chk({nm, "_lat"}, W'(n), W'(elat));
        chk({nm, "_q"}, bus.o_quotient, eq);
        chk({nm, "_r"}, bus.o_remainder, er);
        tick();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 6)
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return W'($urandom % 16);
            4:       return $urandom;
            default: return -W'($urandom % 100);
        endcase
    endfunction

    initial begin
        logic [W-1:0] q, r;
        int dones;
        bus.i_req = 1'b0; bus.i_signed = 1'b0; bus.i_dividend = '0; bus.i_divisor = '0; bus.i_flush = 1'b0;

        ref_div(1'b0, 32'd100, 32'd7, q, r);
        chk("pin_100_7_q", q, 32'd14);
        chk("pin_100_7_r", r, 32'd2);
        ref_div(1'b1, 32'hFFFF_FFF9, 32'd2, q, r);
        chk("pin_m7_2_q", q, 32'hFFFF_FFFD);
        chk("pin_m7_2_r", r, 32'hFFFF_FFFF);
        ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r);
        chk("pin_ovf_q", q, 32'h8000_0000);
        chk("pin_ovf_r", r, 32'd0);

        tick();
        chk_en = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();

        run_op("u100_7",  1'b0, 32'd100,       32'd7,         32'd14,          32'd2,          LAT);
        run_op("s_m7_2",  1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD,   32'hFFFF_FFFF,  LAT);
        run_op("u_m7_2",  1'b0, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC,   32'd1,          LAT);
        run_op("div0",    1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF,   32'd5,          2);
        run_op("ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,   32'd0,          LAT);
        run_op("u100_7b", 1'b0, 32'd100,       32'd7,         32'd14,          32'd2,          LAT);

        // Flush mid-op, then re-accept in the very next cycle.
        drive_req(1'b0, 32'd9, 32'd4);
        tick();
        bus.i_req = 1'b0;
        repeat (9) tick();
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        chk("flush_busy", W'(bus.o_div_busy), '0);
        chk("flush_q", bus.o_quotient, 32'd14);
        chk("flush_r", bus.o_remainder, 32'd2);
        run_op("after_flush", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, LAT);

        drive_req(1'b0, 32'd9, 32'd4);
        bus.i_flush = 1'b1;
        tick();
        bus.i_req = 1'b0; bus.i_flush = 1'b0;
        chk("req_flush_busy", W'(bus.o_div_busy), '0);
        tick();

        // Reset part-way through an op clears everything.
        drive_req(1'b0, 32'd100, 32'd7);
        tick();
        bus.i_req = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_busy", W'(bus.o_div_busy), '0);
        chk("rst_done", W'(bus.o_div_done), '0);
        chk("rst_q", bus.o_quotient, '0);
        chk("rst_r", bus.o_remainder, '0);
        tick();

        // Requests while busy are dropped.
        dones = 0;
        drive_req(1'b0, 32'd100, 32'd7);
        for (int c = 1; c <= 80; c++) begin
            tick();
            bus.i_req = (c == 5 || c == 20);
            if (bus.i_req) begin bus.i_dividend = 32'd50; bus.i_divisor = 32'd3; end
            if (bus.o_div_done) dones++;
            if (c == 36) bus.i_req = 1'b0;
        end
        chk("busy_req_dones", W'(dones), 32'd1);
        chk("busy_req_q", bus.o_quotient, 32'd14);

        for (int c = 0; c < 6000; c++) begin
            bus.i_req      = ($urandom % 3 == 0);
            bus.i_flush    = ($urandom % 80 == 0);
            bus.i_signed   = $urandom % 2;
            bus.i_dividend = pick();
            bus.i_divisor  = pick();
            reset          = ($urandom % 700 == 0);
            tick();
        end
        bus.i_req = 1'b0; bus.i_flush = 1'b0; reset = 1'b0;
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
